// File: rtl/upperimm_exec_stage.sv
// ============================================================================
// Module      : upperimm_exec_stage
// Description : Registered execute stage for RISC-V LUI/AUIPC (XLEN 32/64).
//               Decodes the instruction and computes the writeback value. A
//               2-entry skid FIFO buffers results so in_ready never depends
//               combinationally on out_ready. Also flags illegal opcodes and
//               keeps a saturating count of retired operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module upperimm_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction_code,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  result,
  output logic             wb_en,
  output logic [4:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [4:0] c_ALU_NOP   = 5'd0;
  localparam logic [4:0] c_ALU_LUI   = 5'd1;
  localparam logic [4:0] c_ALU_AUIPC = 5'd2;
  localparam logic [6:0] c_OP_LUI    = 7'h37;
  localparam logic [6:0] c_OP_AUIPC  = 7'h17;

  // Decode fields
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd_in;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_pc_sum;
  logic [4:0]      w_alu;
  logic [XLEN-1:0] w_val;
  logic            w_wb;
  logic            w_ill;

  assign w_opcode = instruction_code[6:0];
  assign w_rd_in  = instruction_code[11:7];
  assign w_imm32  = {instruction_code[31:12], 12'b0};

  // Sign-extend the upper immediate to the datapath width
  generate
    if (XLEN > 32) begin : g_xlen_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_xlen_32
      assign w_imm = w_imm32;
    end
  endgenerate

  assign w_pc_sum = pc + w_imm;

  // Opcode decode and writeback value selection
  always_comb begin
    w_alu = c_ALU_NOP;
    w_val = '0;
    w_wb  = 1'b0;
    w_ill = 1'b0;
    case (w_opcode)
      c_OP_LUI: begin
        w_alu = c_ALU_LUI;
        w_val = w_imm;
        w_wb  = 1'b1;
      end
      c_OP_AUIPC: begin
        w_alu = c_ALU_AUIPC;
        w_val = w_pc_sum;
        w_wb  = 1'b1;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
    // x0 is never written; the entry still retires normally
    if (w_rd_in == 5'd0) begin
      w_val = '0;
      w_wb  = 1'b0;
    end
  end

  // Skid FIFO state
  logic [1:0]      r_cnt;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [4:0]      r_mem_rd  [2];
  logic [XLEN-1:0] r_mem_res [2];
  logic [4:0]      r_mem_alu [2];
  logic            r_mem_wb  [2];
  logic            r_mem_ill [2];
  logic [CNT_W-1:0] r_op_count;

  logic w_push;
  logic w_pop;
  logic w_head;

  assign in_ready  = ~r_cnt[1] & ~rst;
  assign out_valid = (r_cnt != 2'd0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // When empty, point at the slot that was most recently the head so the
  // outputs keep showing the last value instead of a stale older entry.
  assign w_head = (r_cnt == 2'd0) ? ~r_rd_ptr : r_rd_ptr;

  assign rd          = r_mem_rd[w_head];
  assign result      = r_mem_res[w_head];
  assign alu_control = r_mem_alu[w_head];
  assign wb_en       = r_mem_wb[w_head];
  assign illegal     = r_mem_ill[w_head];
  assign op_count    = r_op_count;

  // Entry storage: write the decoded result into the tail slot on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem_rd[i]  <= 5'd0;
        r_mem_res[i] <= '0;
        r_mem_alu[i] <= c_ALU_NOP;
        r_mem_wb[i]  <= 1'b0;
        r_mem_ill[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_mem_rd[r_wr_ptr]  <= w_rd_in;
      r_mem_res[r_wr_ptr] <= w_val;
      r_mem_alu[r_wr_ptr] <= w_alu;
      r_mem_wb[r_wr_ptr]  <= w_wb;
      r_mem_ill[r_wr_ptr] <= w_ill;
    end
  end

  // Pointer and occupancy tracking; flush empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (flush) begin
      r_cnt <= 2'd0;
      // Step past the current head so it stays the displayed entry and the
      // next push lands in the other slot.
      if (r_cnt != 2'd0) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_wr_ptr <= ~r_rd_ptr;
      end
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Saturating count of retired LUI/AUIPC operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_pop && (r_mem_alu[r_rd_ptr] != c_ALU_NOP) && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

endmodule

`default_nettype wire
